// File: rtl/pattern_dect_sched.sv
// pattern_dect_sched: round-robin scheduler time-sharing one overlapping serial
// pattern detector among N_CH requesters. Optional idle watchdog: PDS_TIMEOUT_EN.
module pattern_dect_sched #(
  parameter int N_CH   = 4,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2,
  parameter int TO_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  bit_in,
  input  logic [N_CH-1:0]  bit_vld,
  input  logic [N_CH-1:0]  bit_last,
  output logic [N_CH-1:0]  gnt,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic [CH_W-1:0]  done_ch,
  output logic [CNT_W-1:0] match_cnt,
  output logic             timeout
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  gch_q, gch_d;
  logic [N_CH-1:0]  gnt_q, gnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  done_ch_q, done_ch_d;

  logic [CH_W-1:0]  arb_sel;
  logic [CH_W-1:0]  arb_idx;
  logic             bit_g, vld_g, last_g, req_g;
  logic             acc;
  logic [PAT_W-1:0] shifted;
  logic             to_hit;

  function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
    if (int'(c) >= N_CH - 1) return '0;
    return c + 1'b1;
  endfunction

  // Scan from ptr downwards in reverse so the first requester in ptr order wins.
  always_comb begin
    arb_sel = ptr_q;
    arb_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      arb_idx = CH_W'((int'(ptr_q) + i) % N_CH);
      if (req[arb_idx]) arb_sel = arb_idx;
    end
  end

  assign bit_g   = bit_in[gch_q];
  assign vld_g   = bit_vld[gch_q];
  assign last_g  = bit_last[gch_q];
  assign req_g   = req[gch_q];
  assign acc     = (state_q == RUN) && vld_g;
  assign shifted = {hist_q, bit_g};
  assign match   = acc && (fill_q == FILL_MAX) && (shifted == pat_q);

`ifdef PDS_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] idle_q;
  logic            timeout_q;

  assign to_hit = (state_q == RUN) && !vld_g && (idle_q == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q != RUN) || vld_g) idle_q <= '0;
      else                           idle_q <= idle_q + 1'b1;
      if ((state_q == RUN) && (state_d == DONE)) timeout_q <= to_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gch_d     = gch_q;
    gnt_d     = gnt_q;
    pat_d     = pat_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    done_ch_d = done_ch_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          gch_d   = arb_sel;
          gnt_d   = N_CH'(1) << arb_sel;
          pat_d   = cfg_pattern;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (acc) begin
          hist_d = shifted[PAT_W-2:0];
          if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
        end
        if (match && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        // An accepted last bit beats a simultaneous request drop.
        if (acc && last_g) begin
          state_d   = DONE;
          gnt_d     = '0;
          ptr_d     = ch_inc(gch_q);
          done_ch_d = gch_q;
        end else if (!req_g) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ch_inc(gch_q);
        end else if (to_hit) begin
          state_d   = DONE;
          gnt_d     = '0;
          ptr_d     = ch_inc(gch_q);
          done_ch_d = gch_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gch_q     <= '0;
      gnt_q     <= '0;
      pat_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      done_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gch_q     <= gch_d;
      gnt_q     <= gnt_d;
      pat_q     <= pat_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      done_ch_q <= done_ch_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign done_ch   = done_ch_q;
  assign match_cnt = cnt_q;

endmodule

// File: doc/pattern_dect_sched.md
Name: pattern_dect_sched

Overview:
- Round-robin scheduler that time-shares one serial pattern-match engine among N_CH bit-stream requesters.
- A requester is granted the engine for one whole frame: from grant until the accepted bit flagged last, or until it aborts.
- Engine detects a programmable PAT_W-bit pattern with overlap, emits a Mealy match pulse, and reports the per-frame match count at frame end.
- Sits between the serial channel front-ends and status/interrupt logic.

Parameters:
N_CH, 4, number of requesting channels (2..8)
PAT_W, 4, pattern length in bits (2..8)
CNT_W, 8, match counter width
CH_W, 2, channel index width, >= clog2(N_CH)
TO_CYC, 64, idle-bit timeout in cycles; used only with PDS_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_pattern  in  PAT_W  pattern to detect; MSB is the earliest bit; latched at grant
req  in  N_CH  per-channel request; held high for the whole frame
bit_in  in  N_CH  per-channel serial data
bit_vld  in  N_CH  per-channel data valid
bit_last  in  N_CH  marks the last bit of a frame
gnt  out  N_CH  one-hot grant, registered
busy  out  1  engine owned (RUN state)
match  out  1  Mealy pulse: the accepted bit completes the pattern
done  out  1  one-cycle frame-complete pulse
done_ch  out  CH_W  channel that completed; held until the next done
match_cnt  out  CNT_W  matches in the last frame; held until the next grant
timeout  out  1  frame ended by watchdog; valid with done

Behaviour:
- Reset (async, rst=0): state IDLE; gnt=0, busy=0, done=0, done_ch=0, match_cnt=0, timeout=0; rr pointer=0; history and fill cleared.
- States: IDLE, RUN, DONE.
- IDLE, any req high: select the first requester scanning ptr, ptr+1, … mod N_CH.
  - At the next edge: gnt one-hot, busy=1, pattern latched, history/fill/match_cnt cleared, enter RUN.
  - Latency: req at edge t -> gnt visible after edge t+1.
- RUN, accepting bits:
  - A bit is accepted only when bit_vld[g]=1 for the granted channel g. Non-granted channels' inputs are ignored.
  - History register holds the last PAT_W-1 accepted bits; fill counts accepted bits, saturating at PAT_W-1.
  - match = RUN & bit_vld[g] & (fill==PAT_W-1) & ({hist,bit_in[g]}==pattern). Purely combinational, same cycle as the bit.
  - Overlap allowed: pattern 0000 on stream 00000 gives 2 matches.
  - match_cnt increments on each match and saturates at 2^CNT_W-1.
- RUN, frame end:
  - Accepted bit with bit_last[g]=1: its match still counts. Next edge: gnt=0, busy=0, enter DONE.
- RUN, abort:
  - req[g] falls: next edge returns to IDLE with gnt=0, no done, ptr=(g+1) mod N_CH.
  - If req falls in the same cycle as an accepted last bit, last wins: go to DONE.
- DONE (one cycle): done=1, done_ch=g, timeout as set; ptr=(g+1) mod N_CH; next edge to IDLE.
  - A requester still high after done is re-arbitrated at lowest priority.
- cfg_pattern changes during RUN have no effect on the current frame.
- Reset mid-frame: immediate return to reset values; no done is issued.

Optional Feature:
- Macro PDS_TIMEOUT_EN.
- Defined: in RUN, a counter counts consecutive cycles with no accepted bit. On reaching TO_CYC it forces DONE with timeout=1; match_cnt holds the partial count. The counter clears on each accepted bit and on grant.
- Undefined: no counter is built, timeout is tied to 0, and a stalled frame holds the engine until req falls.

Test Plan:
- Reset mid-RUN (ch1 granted, 3 bits sent), pulse rst low -> gnt=0, busy=0, match_cnt=0 immediately; no done.
- pattern=4'b0000, ch0 sends 0,0,0,0,0(last) -> match high on bits 4 and 5; done=1 with done_ch=0, match_cnt=2.
- pattern=4'b1011, ch2 sends 1,0,1,1,0,1,1(last) -> matches on bits 4 and 7; match_cnt=2; bit_vld gaps between bits do not change the result.
- req=4'b1111 held continuously, each frame 1 bit long -> grants in order ch0, ch1, ch2, ch3, ch0; gnt always one-hot.
- ch3 granted, req[3] dropped after 2 bits, req[1] high -> no done; next grant goes to ch1 (ptr=0 after wrap, ch1 first requester).
- PDS_TIMEOUT_EN, TO_CYC=64: ch0 granted, 2 bits then bit_vld=0 -> done with timeout=1 exactly 64 cycles after the last accepted bit; without the macro busy stays 1.
